// File: rtl/otter_io_ctrl.sv
// OTTER MCU memory-mapped I/O controller.
// Owns the LED register, a multiplexed hex display scanner, switch reads,
// per-button debouncing and a latched, maskable button-press interrupt.
module otter_io_ctrl #(
    parameter int          LED_W      = 16,
    parameter int          SW_W       = 16,
    parameter int          BTN_W      = 5,
    parameter int          NUM_DIGITS = 4,
    parameter int          DB_CYCLES  = 10,
    parameter int          SCAN_DIV   = 16,
    parameter logic [31:0] BASE_IN    = 32'h11008000,
    parameter logic [31:0] BASE_OUT   = 32'h1100C000
) (
    input  logic                  clk,
    input  logic                  RESET_N,
    input  logic [31:0]           IOBUS_ADDR,
    input  logic [31:0]           IOBUS_OUT,
    input  logic                  IOBUS_WR,
    output logic [31:0]           IOBUS_IN,
    output logic                  INTR,
    input  logic [SW_W-1:0]       switches,
    input  logic [BTN_W-1:0]      buttons,
    output logic [LED_W-1:0]      leds,
    output logic [7:0]            segs,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int HEX_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [31:0] ADDR_SW   = BASE_IN;
    localparam logic [31:0] ADDR_BTN  = BASE_IN + 32'h4;
    localparam logic [31:0] ADDR_PEND = BASE_IN + 32'h8;
    localparam logic [31:0] ADDR_LED  = BASE_OUT;
    localparam logic [31:0] ADDR_HEX  = BASE_OUT + 32'h4;
    localparam logic [31:0] ADDR_MASK = BASE_OUT + 32'h8;
    localparam logic [31:0] ADDR_IEN  = BASE_OUT + 32'hC;
    localparam logic [31:0] ADDR_CLR  = BASE_OUT + 32'h10;

    logic [LED_W-1:0]      led_reg;
    logic [HEX_W-1:0]      hex_reg;
    logic [NUM_DIGITS-1:0] mask_reg;
    logic [BTN_W-1:0]      ien_reg;
    logic [BTN_W-1:0]      pend_reg;

    logic [SW_W-1:0]       sw_meta, sw_sync;
    logic [BTN_W-1:0]      btn_meta, btn_sync;
    logic [BTN_W-1:0]      btn_db;
    logic [BTN_W-1:0]      btn_rise;
    logic [CNT_W-1:0]      db_cnt [BTN_W];

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic                  idx_changed;
    logic [3:0]            cur_nibble;
    logic [NUM_DIGITS-1:0] cur_onehot;

    logic                  we_led, we_hex, we_mask, we_ien, we_clr;
    logic [BTN_W-1:0]      clr_bits;
    logic                  bus_unused;

    // Only the low bits of the write data reach the registers
    assign bus_unused = &{1'b0, IOBUS_OUT};

    assign leds = led_reg;

    // Seven-segment decode for one hex nibble, active-low, dp off
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Write strobe decode for the output-side registers
    always_comb begin
        we_led   = IOBUS_WR && (IOBUS_ADDR == ADDR_LED);
        we_hex   = IOBUS_WR && (IOBUS_ADDR == ADDR_HEX);
        we_mask  = IOBUS_WR && (IOBUS_ADDR == ADDR_MASK);
        we_ien   = IOBUS_WR && (IOBUS_ADDR == ADDR_IEN);
        we_clr   = IOBUS_WR && (IOBUS_ADDR == ADDR_CLR);
        clr_bits = we_clr ? IOBUS_OUT[BTN_W-1:0] : '0;
    end

    // Read mux; zero-extended, unmapped addresses return 0
    always_comb begin
        IOBUS_IN = '0;
        case (IOBUS_ADDR)
            ADDR_SW:   IOBUS_IN[SW_W-1:0]       = sw_sync;
            ADDR_BTN:  IOBUS_IN[BTN_W-1:0]      = btn_db;
            ADDR_PEND: IOBUS_IN[BTN_W-1:0]      = pend_reg;
            ADDR_LED:  IOBUS_IN[LED_W-1:0]      = led_reg;
            ADDR_HEX:  IOBUS_IN[HEX_W-1:0]      = hex_reg;
            ADDR_MASK: IOBUS_IN[NUM_DIGITS-1:0] = mask_reg;
            ADDR_IEN:  IOBUS_IN[BTN_W-1:0]      = ien_reg;
            default:   IOBUS_IN                 = '0;
        endcase
    end

    // Software-writable control registers
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            led_reg  <= '0;
            hex_reg  <= '0;
            mask_reg <= '0;
            ien_reg  <= '0;
        end else begin
            if (we_led)  led_reg  <= IOBUS_OUT[LED_W-1:0];
            if (we_hex)  hex_reg  <= IOBUS_OUT[HEX_W-1:0];
            if (we_mask) mask_reg <= IOBUS_OUT[NUM_DIGITS-1:0];
            if (we_ien)  ien_reg  <= IOBUS_OUT[BTN_W-1:0];
        end
    end

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= switches;
            sw_sync  <= sw_meta;
            btn_meta <= buttons;
            btn_sync <= btn_meta;
        end
    end

    // Per-button debounce; a change is accepted after DB_CYCLES stable cycles
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_db   <= '0;
            btn_rise <= '0;
            for (int i = 0; i < BTN_W; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < BTN_W; i++) begin
                btn_rise[i] <= 1'b0;
                if (btn_sync[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    btn_db[i]   <= btn_sync[i];
                    btn_rise[i] <= btn_sync[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pending latch and interrupt; a new press outranks a same-cycle clear
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_reg <= '0;
            INTR     <= 1'b0;
        end else begin
            pend_reg <= (pend_reg & ~clr_bits) | btn_rise;
            INTR     <= |(pend_reg & ien_reg);
        end
    end

    // Select the nibble and anode bit for the digit currently being scanned
    always_comb begin
        cur_nibble = 4'h0;
        cur_onehot = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_idx == IDX_W'(d)) begin
                cur_nibble    = hex_reg[d*4 +: 4];
                cur_onehot[d] = 1'b1;
            end
        end
    end

    // Display scanner: divider, digit index, and registered pin drive
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt     <= '0;
            digit_idx   <= '0;
            idx_changed <= 1'b0;
            segs        <= 8'hFF;
            an          <= '1;
        end else begin
            if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                div_cnt     <= '0;
                idx_changed <= 1'b1;
                if (digit_idx == IDX_W'(NUM_DIGITS - 1)) digit_idx <= '0;
                else                                     digit_idx <= digit_idx + 1'b1;
            end else begin
                div_cnt     <= div_cnt + 1'b1;
                idx_changed <= 1'b0;
            end
            if (idx_changed) begin
                an   <= ~(cur_onehot & mask_reg);
                segs <= seg_decode(cur_nibble);
            end
        end
    end

endmodule

// File: tb/tb_otter_io_ctrl.sv
// Directed, table-driven bench for otter_io_ctrl (SCAN_DIV shortened to 4).
module tb_otter_io_ctrl;

    logic        clk;
    logic        RESET_N;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;
    logic [15:0] switches;
    logic [4:0]  buttons;
    logic [15:0] leds;
    logic [7:0]  segs;
    logic [3:0]  an;

    int total_checks = 0;
    int bad_checks   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expRead;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] expSeg [4];
    logic [3:0] expAn  [4];
    logic       seenToggle;

    otter_io_ctrl #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR),
        .switches   (switches),
        .buttons    (buttons),
        .leds       (leds),
        .segs       (segs),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs despite the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
    endtask

    task automatic busRead(input string name, input logic [31:0] a, input logic [31:0] exp);
        IOBUS_ADDR = a;
        #1;
        checkOutput(name, IOBUS_IN, exp);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        IOBUS_ADDR = v.addr;
        IOBUS_OUT  = v.data;
        IOBUS_WR   = v.wr;
        tick();
        IOBUS_WR   = 1'b0;
        busRead($sformatf("vec%0d", idx), v.addr, v.expRead);
    endtask

    task automatic waitAn(input string name, input logic [3:0] target, input int bound);
        int n = 0;
        while (an !== target && n < bound) begin
            tick();
            n++;
        end
        checkOutput(name, {28'h0, an}, {28'h0, target});
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h1100C000, 32'h0000A5C3, 32'h0000A5C3};
        vecs[1]  = '{1'b0, 32'h1100C000, 32'h00000000, 32'h0000A5C3};
        vecs[2]  = '{1'b0, 32'h1100C014, 32'h00000000, 32'h00000000};
        vecs[3]  = '{1'b1, 32'h1100C004, 32'hFFFF12EF, 32'h000012EF};
        vecs[4]  = '{1'b1, 32'h1100C008, 32'h000000FF, 32'h0000000F};
        vecs[5]  = '{1'b1, 32'h1100C00C, 32'hFFFFFFFF, 32'h0000001F};
        vecs[6]  = '{1'b1, 32'h1100C010, 32'hFFFFFFFF, 32'h00000000};
        vecs[7]  = '{1'b1, 32'h11008000, 32'h00001234, 32'h00005A5A};
        vecs[8]  = '{1'b0, 32'h11008004, 32'h00000000, 32'h00000000};
        vecs[9]  = '{1'b0, 32'h11008008, 32'h00000000, 32'h00000000};
        vecs[10] = '{1'b1, 32'h1100C00C, 32'h00000004, 32'h00000004};
        vecs[11] = '{1'b1, 32'h1100C014, 32'hFFFFFFFF, 32'h00000000};
        expSeg = '{8'h8E, 8'h86, 8'hA4, 8'hF9};

        // Reset held with busy inputs
        RESET_N    = 1'b0;
        switches   = 16'h5A5A;
        buttons    = 5'h1F;
        IOBUS_ADDR = 32'h1100C000;
        IOBUS_OUT  = 32'hFFFFFFFF;
        IOBUS_WR   = 1'b1;
        repeat (4) tick();
        checkOutput("rst_leds", {16'h0, leds}, 32'h0);
        checkOutput("rst_segs", {24'h0, segs}, 32'hFF);
        checkOutput("rst_an", {28'h0, an}, 32'hF);
        checkOutput("rst_intr", {31'h0, INTR}, 32'h0);
        busRead("rst_pend", 32'h11008008, 32'h0);
        busRead("rst_sw", 32'h11008000, 32'h0);
        IOBUS_WR = 1'b0;
        buttons  = 5'h00;
        RESET_N  = 1'b1;
        repeat (4) tick();

        // Register map vectors
        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);
        checkOutput("leds_value", {16'h0, leds}, 32'h0000A5C3);

        // Display scan with all digits enabled
        expAn = '{4'hE, 4'hD, 4'hB, 4'h7};
        waitAn("scan_sync_a", 4'h7, 40);
        waitAn("scan_sync_b", 4'hE, 40);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("scan_seg%0d", k), {24'h0, segs}, {24'h0, expSeg[(k/4)%4]});
            checkOutput($sformatf("scan_an%0d", k), {28'h0, an}, {28'h0, expAn[(k/4)%4]});
            tick();
        end

        // Display scan with digit mask 0x5
        busWrite(32'h1100C008, 32'h5);
        repeat (20) tick();
        expAn = '{4'hE, 4'hF, 4'hB, 4'hF};
        waitAn("mask_sync_a", 4'hF, 40);
        waitAn("mask_sync_b", 4'hE, 40);
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("mask_seg%0d", k), {24'h0, segs}, {24'h0, expSeg[(k/4)%4]});
            checkOutput($sformatf("mask_an%0d", k), {28'h0, an}, {28'h0, expAn[(k/4)%4]});
            tick();
        end

        // Bouncing button 2: 3-cycle pulses must never be accepted
        IOBUS_ADDR = 32'h11008004;
        seenToggle = 1'b0;
        for (int c = 0; c < 40; c++) begin
            buttons[2] = ((c / 3) % 2) == 0;
            tick();
            seenToggle = seenToggle | IOBUS_IN[2];
        end
        checkOutput("bounce_no_toggle", {31'h0, seenToggle}, 32'h0);

        // Stable press: accepted after sync + DB_CYCLES, then PEND, then INTR
        buttons[2] = 1'b1;
        repeat (11) tick();
        busRead("db_before", 32'h11008004, 32'h0);
        tick();
        busRead("db_accept", 32'h11008004, 32'h4);
        busRead("pend_lag", 32'h11008008, 32'h0);
        tick();
        busRead("pend_set", 32'h11008008, 32'h4);
        checkOutput("intr_lag", {31'h0, INTR}, 32'h0);
        tick();
        checkOutput("intr_set", {31'h0, INTR}, 32'h1);

        // Write-one-to-clear
        busWrite(32'h1100C010, 32'h4);
        busRead("w1c_pend", 32'h11008008, 32'h0);
        checkOutput("w1c_intr_lag", {31'h0, INTR}, 32'h1);
        tick();
        checkOutput("w1c_intr", {31'h0, INTR}, 32'h0);

        // Release is not an interrupt source
        buttons[2] = 1'b0;
        repeat (16) tick();
        busRead("release_pend", 32'h11008008, 32'h0);

        // Press with interrupts disabled still latches PEND
        busWrite(32'h1100C00C, 32'h0);
        buttons[2] = 1'b1;
        repeat (14) tick();
        busRead("noien_pend", 32'h11008008, 32'h4);
        checkOutput("noien_intr", {31'h0, INTR}, 32'h0);
        busWrite(32'h1100C00C, 32'h4);
        tick();
        checkOutput("ien_on_intr", {31'h0, INTR}, 32'h1);

        // Clear on the same edge as a new press: the set wins
        buttons[2] = 1'b0;
        repeat (16) tick();
        busRead("pre_same_pend", 32'h11008008, 32'h4);
        buttons[2] = 1'b1;
        repeat (12) tick();
        busWrite(32'h1100C010, 32'h4);
        busRead("same_pend", 32'h11008008, 32'h4);
        tick();
        checkOutput("same_intr", {31'h0, INTR}, 32'h1);
        tick();
        checkOutput("same_intr_hold", {31'h0, INTR}, 32'h1);

        // Asynchronous reset mid-operation clears everything immediately
        #3;
        RESET_N = 1'b0;
        #1;
        checkOutput("arst_leds", {16'h0, leds}, 32'h0);
        checkOutput("arst_intr", {31'h0, INTR}, 32'h0);
        checkOutput("arst_segs", {24'h0, segs}, 32'hFF);
        checkOutput("arst_an", {28'h0, an}, 32'hF);
        busRead("arst_pend", 32'h11008008, 32'h0);
        busRead("arst_btn", 32'h11008004, 32'h0);
        busRead("arst_hex", 32'h1100C004, 32'h0);
        repeat (3) tick();
        RESET_N = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
